// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART receive controller.
//   state_t       - receive FSM state encoding
//   PRESC_8/16/32 - legal clocks-per-bit values for the prescale input
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  localparam int unsigned PRESC_8  = 8;
  localparam int unsigned PRESC_16 = 16;
  localparam int unsigned PRESC_32 = 32;

endpackage

// File: rtl/edge_bit_counter.sv
// edge_bit_counter: clock-within-bit and bit-within-frame counters.
// Ports:
//   clk, rst       - clock, async active-low reset
//   en             - count enable (high while a frame is in progress)
//   last           - the current bit is the last one of the frame; bit_cnt
//                    returns to 0 at its end instead of advancing
//   prescale       - clocks per bit
//   edge_cnt       - clock index within the current bit
//   bit_cnt        - bit index within the frame
//   bit_end        - high on the final clock of a bit
module edge_bit_counter #(
  parameter int PRESC_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               last,
  input  logic [PRESC_W-1:0] prescale,
  output logic [PRESC_W-1:0] edge_cnt,
  output logic [3:0]         bit_cnt,
  output logic               bit_end
);

  // >= rather than == so a prescale lowered mid-frame cannot strand the
  // counter above the new terminal value.
  assign bit_end = en && (edge_cnt >= (prescale - PRESC_W'(1)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (!en) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (bit_end) begin
      edge_cnt <= '0;
      bit_cnt  <= last ? 4'd0 : bit_cnt + 4'd1;
    end else begin
      edge_cnt <= edge_cnt + PRESC_W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm: sequencing controller for a UART receive path. Walks a frame
// through start, data, optional parity and stop bits, enabling the external
// sampler, deserializer and checkers at the right time, and flags a good
// frame with a one-clock data_valid.
// Ports:
//   clk, rst                  - clock, async active-low reset
//   rx_in                     - serial line (idle high)
//   par_en                    - frame carries a parity bit
//   prescale                  - clocks per bit (8, 16 or 32)
//   strt_glitch/par_err/stp_err - results from the external checkers
//   dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en
//                             - enables for the receive-path blocks
//   data_valid                - one-clock pulse for an error-free frame
//   edge_cnt, bit_cnt         - position within bit / frame
//
// state  | meaning
// IDLE   | line idle, waiting for a falling rx_in
// START  | start bit, start checker enabled
// DATA   | data bits 1..DATA_WIDTH, deserializer strobed mid-bit
// PARITY | parity bit, parity checker enabled
// STOP   | stop bit, stop checker enabled
// DONE   | one clock; data_valid if no error was latched
module uart_rx_fsm
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx_in,
  input  logic               par_en,
  input  logic [PRESC_W-1:0] prescale,
  input  logic               strt_glitch,
  input  logic               par_err,
  input  logic               stp_err,
  output logic               dat_samp_en,
  output logic               deser_en,
  output logic               strt_chk_en,
  output logic               par_chk_en,
  output logic               stp_chk_en,
  output logic               data_valid,
  output logic [PRESC_W-1:0] edge_cnt,
  output logic [3:0]         bit_cnt
);

  localparam logic [3:0] LAST_DATA = 4'(DATA_WIDTH);

  state_t             state;
  state_t             state_nxt;
  logic               err_q;
  logic               cnt_en;
  logic               cnt_last;
  logic               bit_end;
  logic [PRESC_W-1:0] samp_pt;

  assign cnt_en   = (state != ST_IDLE) && (state != ST_DONE);
  assign cnt_last = (state == ST_STOP) || ((state == ST_START) && strt_glitch);
  // The external sampler needs a couple of clocks past mid-bit to settle.
  assign samp_pt  = (prescale >> 1) + PRESC_W'(2);

  edge_bit_counter #(.PRESC_W(PRESC_W)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .en       (cnt_en),
    .last     (cnt_last),
    .prescale (prescale),
    .edge_cnt (edge_cnt),
    .bit_cnt  (bit_cnt),
    .bit_end  (bit_end)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else begin
      case (state)
        ST_PARITY: if (bit_end) err_q <= err_q | par_err;
        ST_STOP:   if (bit_end) err_q <= err_q | stp_err;
        ST_DONE:   err_q <= 1'b0;
        default:   err_q <= err_q;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (!rx_in) state_nxt = ST_START;
      ST_START:  if (bit_end) state_nxt = strt_glitch ? ST_IDLE : ST_DATA;
      ST_DATA:   if (bit_end && (bit_cnt >= LAST_DATA))
                   state_nxt = par_en ? ST_PARITY : ST_STOP;
      ST_PARITY: if (bit_end) state_nxt = ST_STOP;
      ST_STOP:   if (bit_end) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = rx_in ? ST_IDLE : ST_START;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    dat_samp_en = 1'b0;
    deser_en    = 1'b0;
    strt_chk_en = 1'b0;
    par_chk_en  = 1'b0;
    stp_chk_en  = 1'b0;
    data_valid  = 1'b0;
    case (state)
      ST_START: begin
        dat_samp_en = 1'b1;
        strt_chk_en = 1'b1;
      end
      ST_DATA: begin
        dat_samp_en = 1'b1;
        deser_en    = (edge_cnt == samp_pt);
      end
      ST_PARITY: begin
        dat_samp_en = 1'b1;
        par_chk_en  = 1'b1;
      end
      ST_STOP: begin
        dat_samp_en = 1'b1;
        stp_chk_en  = 1'b1;
      end
      ST_DONE: data_valid = !err_q;
      default: ;
    endcase
  end

endmodule
